// File: rtl/ysyx_23060332_dmem.sv
// Data memory with valid/ready request and response channels.
// Define YSYX_23060332_DMEM_LATENCY_EN to add LATENCY wait cycles per access.
module ysyx_23060332_dmem #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          LATENCY   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH * 8);

`ifdef YSYX_23060332_DMEM_LATENCY_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RESP = 2'd2
   } state_t;
`endif

   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
         $error("LATENCY must be in 1..15");
      end
   endgenerate

   state_t       r_state;
   state_t       w_nxt;
   logic [63:0]  r_mem [DEPTH];
   logic [63:0]  r_rdata;
   logic         r_err;
   logic         w_hs;
   logic         w_enter;
   logic         w_in;
   logic [AW-1:0] w_idx;
   logic         w_a_wen;
   logic [31:0]  w_a_addr;
   logic [63:0]  w_a_wdata;
   logic [7:0]   w_a_wmask;

   assign w_hs = req_valid && req_ready;

`ifdef YSYX_23060332_DMEM_LATENCY_EN
   logic        r_wen;
   logic [31:0] r_addr;
   logic [63:0] r_wdata;
   logic [7:0]  r_wmask;
   logic [3:0]  r_cnt;

   // The access is performed from the request register when WAIT expires.
   assign w_a_wen   = r_wen;
   assign w_a_addr  = r_addr;
   assign w_a_wdata = r_wdata;
   assign w_a_wmask = r_wmask;
   assign w_enter   = rst_n && (r_state == WAIT) && (r_cnt == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_cnt   <= '0;
      end else if (w_hs) begin
         r_wen   <= req_wen;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_wmask <= req_wmask;
         r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end
`else
   // Without wait states the access happens on the handshake edge itself.
   assign w_a_wen   = req_wen;
   assign w_a_addr  = req_addr;
   assign w_a_wdata = req_wdata;
   assign w_a_wmask = req_wmask;
   assign w_enter   = rst_n && w_hs;
`endif

   assign w_in  = ({1'b0, w_a_addr} >= {1'b0, BASE_ADDR})
               && ({1'b0, w_a_addr} < LIMIT);
   assign w_idx = AW'((w_a_addr - BASE_ADDR) >> 3);

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         IDLE: begin
`ifdef YSYX_23060332_DMEM_LATENCY_EN
            if (w_hs) w_nxt = WAIT;
`else
            if (w_hs) w_nxt = RESP;
`endif
         end
`ifdef YSYX_23060332_DMEM_LATENCY_EN
         WAIT: if (r_cnt == 4'd0) w_nxt = RESP;
`endif
         RESP: if (resp_ready) w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_enter) begin
            r_rdata <= (w_in && !w_a_wen) ? r_mem[w_idx] : 64'd0;
            r_err   <= !w_in;
         end
      end
   end

   // Array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_enter && w_in && w_a_wen) begin
         for (int i = 0; i < 8; i++) begin
            if (w_a_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_a_wdata[8*i +: 8];
         end
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign resp_valid = (r_state == RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_ysyx_23060332_dmem.sv
// Directed scoreboard bench for ysyx_23060332_dmem.
// Honours YSYX_23060332_DMEM_LATENCY_EN for expected latency.
module tb_ysyx_23060332_dmem;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

`ifdef YSYX_23060332_DMEM_LATENCY_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] model[int];
   int          checks = 0;
   int          errors = 0;

   ysyx_23060332_dmem dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wmask  (req_wmask),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old,
                                         input logic [63:0] nw,
                                         input logic [7:0] m);
      logic [63:0] r;
      r = old;
      for (int i = 0; i < 8; i++)
         if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   // Drive one request, push its expected response, wait for resp_valid.
   task automatic issue(input logic wen, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] m,
                        output int lat);
      exp_t e;
      logic inr;
      int   idx;
      inr = (addr >= 32'h8000_0000) && (addr < 32'h8000_0800);
      idx = int'((addr - 32'h8000_0000) >> 3);
      e.err = !inr;
      e.rdata = 64'd0;
      if (inr && wen) begin
         model[idx] = merge(model.exists(idx) ? model[idx] : 64'd0, wd, m);
      end else if (inr) begin
         e.rdata = model[idx];
      end
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wd;
      req_wmask = m;
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 50) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic check_resp(input string tag);
      exp_t e;
      e = sb.pop_front();
      chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_err"}, 64'(resp_err), 64'(e.err));
   endtask

   task automatic txn(input logic wen, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [7:0] m,
                      input string tag);
      int lat;
      issue(wen, addr, wd, m, lat);
      chk({tag, "_lat"}, 64'(lat), 64'(LAT));
      check_resp(tag);
      @(posedge clk);
      #1 chk({tag, "_drop"}, 64'(resp_valid), 64'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rv"}, 64'(resp_valid), 64'd0);
      chk({tag, "_rd"}, resp_rdata, 64'd0);
      chk({tag, "_re"}, 64'(resp_err), 64'd0);
      chk({tag, "_rr"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      exp_t e;
      int   lat;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_wmask  = '0;
      resp_ready = 1'b1;
      #2 chk_reset_vals("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      txn(1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, "wr_full");
      txn(1'b1, 32'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, "wr_part");
      txn(1'b0, 32'h8000_0010, 64'd0, 8'h00, "rd_part");
      chk("model_part", model[2], 64'h1122_3344_BBBB_BBBB);

      txn(1'b1, 32'h8000_0000, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, "wr_w0");
      txn(1'b0, 32'h8000_0800, 64'd0, 8'h00, "rd_oob_hi");
      txn(1'b1, 32'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "wr_oob_lo");
      txn(1'b0, 32'h7FFF_FFF8, 64'd0, 8'h00, "rd_oob_lo");
      txn(1'b0, 32'h8000_0004, 64'd0, 8'h00, "rd_w0_ofs");

      txn(1'b1, 32'h8000_0010, 64'h5555_5555_5555_5555, 8'h00, "wr_m0");
      txn(1'b0, 32'h8000_0010, 64'd0, 8'h00, "rd_m0");
      txn(1'b1, 32'h8000_07F8, 64'hCAFE_F00D_1234_5678, 8'hA5, "wr_last");
      txn(1'b0, 32'h8000_07F8, 64'd0, 8'h00, "rd_last");

      // Response back-pressure with ignored request pulses.
      resp_ready = 1'b0;
      issue(1'b0, 32'h8000_0010, 64'd0, 8'h00, lat);
      chk("stall_lat", 64'(lat), 64'(LAT));
      e = sb[0];
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", 64'(resp_valid), 64'd1);
         chk("stall_rdata", resp_rdata, e.rdata);
         chk("stall_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
         req_valid = 1'b1;
         req_wen   = 1'b1;
         req_addr  = 32'h8000_0010;
         req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
         req_wmask = 8'hFF;
         @(posedge clk);
         #1 req_valid = 1'b0;
      end
      check_resp("stall");
      resp_ready = 1'b1;
      @(posedge clk);
      #1 chk("stall_drop", 64'(resp_valid), 64'd0);
      repeat (3) @(posedge clk);
      #1 chk("stall_nobuf", 64'(resp_valid), 64'd0);
      txn(1'b0, 32'h8000_0010, 64'd0, 8'h00, "rd_after_stall");

`ifdef YSYX_23060332_DMEM_LATENCY_EN
      // Reset while a write waits: the write must be lost.
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_addr  = 32'h8000_0010;
      req_wdata = 64'h0123_4567_89AB_CDEF;
      req_wmask = 8'hFF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("rst_wait");
      @(negedge clk);
      rst_n = 1'b1;
`else
      // Reset while a response is held: it must vanish.
      resp_ready = 1'b0;
      issue(1'b0, 32'h8000_0000, 64'd0, 8'h00, lat);
      void'(sb.pop_front());
      chk("rst_resp_pre", 64'(resp_valid), 64'd1);
      rst_n = 1'b0;
      #1 chk_reset_vals("rst_resp");
      @(negedge clk);
      rst_n = 1'b1;
      resp_ready = 1'b1;
`endif
      txn(1'b0, 32'h8000_0010, 64'd0, 8'h00, "rd_after_rst");

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
